multi_cycle_ctrl: RTL and testbench
===================================

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, 15, max wait cycles for imem_ack/dmem_ack before fault (range 2..255).
REQ-002 clk  input  1  rising-edge clock; the block has one clock domain.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 instr  input  32  current instruction register contents; opcode = instr[31:29].
REQ-005 imem_ack  input  1  instruction memory has returned data this cycle.
REQ-006 dmem_ack  input  1  data memory access complete this cycle.
REQ-007 branch_cond  input  1  ALU branch-condition flag, valid in EXEC.
REQ-008 imem_req  output  1  instruction fetch request.
REQ-009 dmem_req / dmem_we  output  1 each  data access request / write strobe.
REQ-010 ir_we / pc_we / pc_src  output  1 each  IR load; PC load; PC source (0 = PC+4, 1 = branch target).
REQ-011 reg_we / wb_sel  output  1 each  register write; writeback source (0 = ALU, 1 = memory).
REQ-012 alu_src_imm / imm_sel  output  1 each  ALU operand B = immediate; immediate mux select (1 = memory-type, 0 = I-type).
REQ-013 state  output  3  current state encoding.
REQ-014 halted / err  output  1 each  sticky halt / sticky fault.
REQ-015 instr_count  output  16  retired-instruction counter.

Function
REQ-016 Opcodes SHALL decode as: 000 R-ALU, 001 I-ALU, 010 load, 011 store, 100 branch, 111 halt; 101/110 SHALL be illegal.
REQ-017 State encodings SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERROR=6; code 7 SHALL transition to ERROR.
REQ-018 FETCH: imem_req=1 every cycle; on imem_ack, ir_we=1 and pc_we=1 (pc_src=0) in that same cycle, next state DECODE.
REQ-019 DECODE: one cycle, no strobes; halt -> HALT, illegal -> ERROR, else -> EXEC.
REQ-020 EXEC: one cycle; alu_src_imm=1 for I-ALU/load/store; imm_sel=1 for load/store, 0 otherwise; R/I-ALU -> WB; load/store -> MEM; branch -> FETCH, with pc_we=1 and pc_src=1 only if branch_cond=1.
REQ-021 MEM: dmem_req=1, dmem_we=1 only for store; imm_sel and alu_src_imm held at 1; on dmem_ack, load -> WB, store -> FETCH.
REQ-022 WB: one cycle; reg_we=1; wb_sel=1 for load, 0 for ALU ops; next state FETCH.
REQ-023 All outputs not named active in a state SHALL be 0 in that state.
REQ-024 A wait counter SHALL clear on entry to FETCH or MEM and increment each cycle without ack; if the counter equals MEM_TIMEOUT-1 and ack is low, next state SHALL be ERROR.
REQ-025 Ack and timeout in the same cycle: ack SHALL win.
REQ-026 Ack while not in FETCH or MEM SHALL be ignored.
REQ-027 instr_count SHALL increment by 1 on the WB->FETCH transition, store MEM->FETCH, and branch EXEC->FETCH, and SHALL wrap from 0xFFFF to 0x0000.
REQ-028 HALT and ERROR SHALL be absorbing until reset; halted=1 in HALT, err=1 in ERROR; no request strobes.
REQ-029 Latency: R-ALU = fetch latency + 3 cycles; load = fetch + data latency + 3; branch = fetch + 2.

Reset
REQ-030 rst_n low SHALL immediately force state=FETCH, wait counter=0, instr_count=0, halted=0, err=0, and all strobes to 0.
REQ-031 Reset asserted mid-MEM SHALL drop dmem_req asynchronously; no write strobe SHALL follow reset release.
REQ-032 On the first clk edge after rst_n rises, imem_req SHALL be 1.

Verification
REQ-033 R-ALU (instr[31:29]=000), imem_ack in cycle 2 -> FETCH, DECODE, EXEC, WB; reg_we=1 for one cycle; wb_sel=0; instr_count=1.
REQ-034 Load (010, instr[27]=1), dmem_ack after 3 MEM cycles -> imm_sel=1 and alu_src_imm=1 through EXEC and MEM; WB with wb_sel=1; instr_count=1.
REQ-035 Branch with branch_cond=1 -> in EXEC, pc_we=1 and pc_src=1; next state FETCH; with branch_cond=0, pc_we=0.
REQ-036 imem_ack held low with MEM_TIMEOUT=15 -> ERROR after 15 FETCH cycles and err=1; ack on the 15th cycle -> DECODE instead.
REQ-037 Opcode 110 -> DECODE then ERROR; opcode 111 -> HALT with halted=1; both hold until rst_n=0.
REQ-038 Preload 0xFFFF retirements, then one more -> instr_count=0x0000; rst_n pulse mid-MEM store -> dmem_req falls without waiting for a clk edge.

Source files
------------

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control FSM: fetch/decode/exec/mem/wb sequencing,
// memory-ack timeout fault, sticky halt/error and retirement counter.
module multi_cycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        imem_ack,
   input  logic        dmem_ack,
   input  logic        branch_cond,
   output logic        imem_req,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic        ir_we,
   output logic        pc_we,
   output logic        pc_src,
   output logic        reg_we,
   output logic        wb_sel,
   output logic        alu_src_imm,
   output logic        imm_sel,
   output logic [2:0]  state,
   output logic        halted,
   output logic        err,
   output logic [15:0] instr_count
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5,
      S_ERROR  = 3'd6
   } state_e;

   localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [7:0]  wait_q, wait_d;
   logic [15:0] cnt_q, cnt_d;
   logic        halted_q, err_q;
   logic        retire;

   logic [2:0] op;
   logic is_ralu, is_ialu, is_ld, is_st, is_br, is_halt, is_ill;
   logic timeout;
   logic unused_instr;

   assign op           = instr[31:29];
   assign unused_instr = ^instr[28:0];
   assign is_ralu      = (op == 3'b000);
   assign is_ialu      = (op == 3'b001);
   assign is_ld        = (op == 3'b010);
   assign is_st        = (op == 3'b011);
   assign is_br        = (op == 3'b100);
   assign is_halt      = (op == 3'b111);
   assign is_ill       = (op == 3'b101) || (op == 3'b110);
   assign timeout      = (wait_q == TO_LAST);

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      retire  = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            if (imem_ack)     state_d = S_DECODE;
            else if (timeout) state_d = S_ERROR;
            else              wait_d  = wait_q + 8'd1;
         end
         S_DECODE: begin
            if (is_halt)     state_d = S_HALT;
            else if (is_ill) state_d = S_ERROR;
            else             state_d = S_EXEC;
         end
         S_EXEC: begin
            wait_d = 8'd0;
            if (is_ralu || is_ialu)  state_d = S_WB;
            else if (is_ld || is_st) state_d = S_MEM;
            else if (is_br) begin
               state_d = S_FETCH;
               retire  = 1'b1;
            end else state_d = S_ERROR;
         end
         S_MEM: begin
            if (dmem_ack) begin
               if (is_ld) state_d = S_WB;
               else if (is_st) begin
                  state_d = S_FETCH;
                  wait_d  = 8'd0;
                  retire  = 1'b1;
               end else state_d = S_ERROR;
            end else if (timeout) state_d = S_ERROR;
            else wait_d = wait_q + 8'd1;
         end
         S_WB: begin
            state_d = S_FETCH;
            wait_d  = 8'd0;
            retire  = 1'b1;
         end
         S_HALT:  state_d = S_HALT;
         S_ERROR: state_d = S_ERROR;
         default: state_d = S_ERROR;
      endcase
      cnt_d = retire ? cnt_q + 16'd1 : cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_FETCH;
         wait_q   <= 8'd0;
         cnt_q    <= 16'd0;
         halted_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         cnt_q    <= cnt_d;
         halted_q <= halted_q | (state_d == S_HALT);
         err_q    <= err_q | (state_d == S_ERROR);
      end
   end

   // Strobes follow the acks in the same cycle, so they are decoded from
   // state; gating with rst_n keeps them low while reset is held.
   logic in_f, in_x, in_m, in_w, br_take, ldst;
   assign in_f    = rst_n && (state_q == S_FETCH);
   assign in_x    = rst_n && (state_q == S_EXEC);
   assign in_m    = rst_n && (state_q == S_MEM);
   assign in_w    = rst_n && (state_q == S_WB);
   assign br_take = in_x && is_br && branch_cond;
   assign ldst    = is_ld || is_st;

   assign imem_req    = in_f;
   assign ir_we       = in_f && imem_ack;
   assign pc_we       = (in_f && imem_ack) || br_take;
   assign pc_src      = br_take;
   assign dmem_req    = in_m;
   assign dmem_we     = in_m && is_st;
   assign reg_we      = in_w;
   assign wb_sel      = in_w && is_ld;
   assign alu_src_imm = (in_x && (is_ialu || ldst)) || (in_m && ldst);
   assign imm_sel     = (in_x || in_m) && ldst;
   assign state       = state_q;
   assign halted      = halted_q;
   assign err         = err_q;
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed table-driven bench for multi_cycle_ctrl plus hand sequences
// for timeout, illegal/halt, counter wrap and asynchronous reset.
module tb_multi_cycle_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] instr = '0;
   logic        imem_ack = 1'b0, dmem_ack = 1'b0, branch_cond = 1'b0;
   logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src;
   logic        reg_we, wb_sel, alu_src_imm, imm_sel, halted, err;
   logic [2:0]  state;
   logic [15:0] instr_count;

   int total = 0;
   int bad = 0;

   multi_cycle_ctrl #(.MEM_TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr),
      .imem_ack(imem_ack), .dmem_ack(dmem_ack),
      .branch_cond(branch_cond), .imem_req(imem_req),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we),
      .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
      .wb_sel(wb_sel), .alu_src_imm(alu_src_imm),
      .imm_sel(imm_sel), .state(state), .halted(halted),
      .err(err), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   // {imem_req,ir_we,pc_we,pc_src,dmem_req,dmem_we,reg_we,wb_sel,alu_src_imm,imm_sel}
   localparam logic [9:0] S_0     = 10'b0000000000;
   localparam logic [9:0] S_F     = 10'b1000000000;
   localparam logic [9:0] S_FA    = 10'b1110000000;
   localparam logic [9:0] S_RW    = 10'b0000001000;
   localparam logic [9:0] S_LW    = 10'b0000001100;
   localparam logic [9:0] S_EXM   = 10'b0000000011;
   localparam logic [9:0] S_EXI   = 10'b0000000010;
   localparam logic [9:0] S_MEML  = 10'b0000100011;
   localparam logic [9:0] S_MEMS  = 10'b0000110011;
   localparam logic [9:0] S_BR    = 10'b0011000000;

   typedef struct {
      logic [2:0]  op;
      logic        ia;
      logic        da;
      logic        bc;
      logic [2:0]  st;
      logic [9:0]  sb;
      logic [15:0] cnt;
   } vec_t;

   vec_t tbl[31];

   function automatic logic [9:0] strobes();
      return {imem_req, ir_we, pc_we, pc_src, dmem_req, dmem_we,
              reg_we, wb_sel, alu_src_imm, imm_sel};
   endfunction

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic drv(input logic [2:0] op, input logic ia,
                      input logic da, input logic bc);
      instr       = {op, 1'b0, 1'b1, 27'd0};
      imem_ack    = ia;
      dmem_ack    = da;
      branch_cond = bc;
      #1;
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      instr = '0;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      branch_cond = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      tbl[0]  = '{3'd0, 1'b0, 1'b0, 1'b0, 3'd0, S_F,   16'd0};
      tbl[1]  = '{3'd0, 1'b1, 1'b0, 1'b0, 3'd0, S_FA,  16'd0};
      tbl[2]  = '{3'd0, 1'b0, 1'b0, 1'b0, 3'd1, S_0,   16'd0};
      tbl[3]  = '{3'd0, 1'b0, 1'b0, 1'b0, 3'd2, S_0,   16'd0};
      tbl[4]  = '{3'd0, 1'b0, 1'b0, 1'b0, 3'd4, S_RW,  16'd0};
      tbl[5]  = '{3'd2, 1'b1, 1'b0, 1'b0, 3'd0, S_FA,  16'd1};
      tbl[6]  = '{3'd2, 1'b0, 1'b0, 1'b0, 3'd1, S_0,   16'd1};
      tbl[7]  = '{3'd2, 1'b0, 1'b0, 1'b0, 3'd2, S_EXM, 16'd1};
      tbl[8]  = '{3'd2, 1'b0, 1'b0, 1'b0, 3'd3, S_MEML,16'd1};
      tbl[9]  = '{3'd2, 1'b0, 1'b0, 1'b0, 3'd3, S_MEML,16'd1};
      tbl[10] = '{3'd2, 1'b0, 1'b1, 1'b0, 3'd3, S_MEML,16'd1};
      tbl[11] = '{3'd2, 1'b0, 1'b0, 1'b0, 3'd4, S_LW,  16'd1};
      tbl[12] = '{3'd3, 1'b1, 1'b0, 1'b0, 3'd0, S_FA,  16'd2};
      tbl[13] = '{3'd3, 1'b0, 1'b0, 1'b0, 3'd1, S_0,   16'd2};
      tbl[14] = '{3'd3, 1'b0, 1'b0, 1'b0, 3'd2, S_EXM, 16'd2};
      tbl[15] = '{3'd3, 1'b0, 1'b1, 1'b0, 3'd3, S_MEMS,16'd2};
      tbl[16] = '{3'd4, 1'b1, 1'b0, 1'b0, 3'd0, S_FA,  16'd3};
      tbl[17] = '{3'd4, 1'b0, 1'b0, 1'b0, 3'd1, S_0,   16'd3};
      tbl[18] = '{3'd4, 1'b0, 1'b0, 1'b1, 3'd2, S_BR,  16'd3};
      tbl[19] = '{3'd4, 1'b1, 1'b0, 1'b0, 3'd0, S_FA,  16'd4};
      tbl[20] = '{3'd4, 1'b0, 1'b0, 1'b1, 3'd1, S_0,   16'd4};
      tbl[21] = '{3'd4, 1'b0, 1'b0, 1'b0, 3'd2, S_0,   16'd4};
      tbl[22] = '{3'd1, 1'b1, 1'b0, 1'b0, 3'd0, S_FA,  16'd5};
      tbl[23] = '{3'd1, 1'b0, 1'b0, 1'b0, 3'd1, S_0,   16'd5};
      tbl[24] = '{3'd1, 1'b0, 1'b0, 1'b0, 3'd2, S_EXI, 16'd5};
      tbl[25] = '{3'd1, 1'b0, 1'b0, 1'b0, 3'd4, S_RW,  16'd5};
      tbl[26] = '{3'd0, 1'b1, 1'b1, 1'b0, 3'd0, S_FA,  16'd6};
      tbl[27] = '{3'd0, 1'b1, 1'b1, 1'b0, 3'd1, S_0,   16'd6};
      tbl[28] = '{3'd0, 1'b1, 1'b1, 1'b0, 3'd2, S_0,   16'd6};
      tbl[29] = '{3'd0, 1'b1, 1'b1, 1'b0, 3'd4, S_RW,  16'd6};
      tbl[30] = '{3'd0, 1'b0, 1'b0, 1'b0, 3'd0, S_F,   16'd7};

      // reset state while rst_n is held low
      #1 rst_n = 1'b0;
      #1;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_strobes", 32'(strobes()), 32'd0);
      chk("rst_count", 32'(instr_count), 32'd0);
      chk("rst_flags", 32'({halted, err}), 32'd0);
      do_reset();

      for (int i = 0; i < 31; i++) begin
         drv(tbl[i].op, tbl[i].ia, tbl[i].da, tbl[i].bc);
         chk($sformatf("v%0d_state", i), 32'(state), 32'(tbl[i].st));
         chk($sformatf("v%0d_strb", i), 32'(strobes()), 32'(tbl[i].sb));
         chk($sformatf("v%0d_cnt", i), 32'(instr_count), 32'(tbl[i].cnt));
         adv();
      end
      chk("tbl_flags", 32'({halted, err}), 32'd0);

      // asynchronous reset clears the counter without a clock edge
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("async_cnt", 32'(instr_count), 32'd0);
      chk("async_strobes", 32'(strobes()), 32'd0);

      // fetch timeout: 15 ack-less FETCH cycles then ERROR
      do_reset();
      for (int i = 0; i < 15; i++) begin
         drv(3'd0, 1'b0, 1'b0, 1'b0);
         chk($sformatf("to_fetch%0d", i), 32'(state), 32'd0);
         adv();
      end
      drv(3'd0, 1'b1, 1'b1, 1'b0);
      chk("to_state", 32'(state), 32'd6);
      chk("to_err", 32'(err), 32'd1);
      chk("to_strobes", 32'(strobes()), 32'd0);
      adv();
      chk("to_hold", 32'(state), 32'd6);

      // ack on the 15th cycle beats the timeout
      do_reset();
      for (int i = 0; i < 14; i++) begin
         drv(3'd0, 1'b0, 1'b0, 1'b0);
         adv();
      end
      drv(3'd0, 1'b1, 1'b0, 1'b0);
      chk("ack15_irwe", 32'(ir_we), 32'd1);
      adv();
      drv(3'd0, 1'b0, 1'b0, 1'b0);
      chk("ack15_state", 32'(state), 32'd1);
      chk("ack15_err", 32'(err), 32'd0);

      // illegal opcode 110
      do_reset();
      drv(3'd6, 1'b1, 1'b0, 1'b0);
      adv();
      chk("ill_decode", 32'(state), 32'd1);
      adv();
      chk("ill_state", 32'(state), 32'd6);
      chk("ill_err", 32'(err), 32'd1);
      drv(3'd0, 1'b1, 1'b0, 1'b0);
      repeat (3) adv();
      chk("ill_hold", 32'(state), 32'd6);
      chk("ill_strobes", 32'(strobes()), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("ill_rst_err", 32'(err), 32'd0);

      // halt opcode 111
      do_reset();
      drv(3'd7, 1'b1, 1'b0, 1'b0);
      adv();
      drv(3'd7, 1'b0, 1'b0, 1'b0);
      adv();
      chk("halt_state", 32'(state), 32'd5);
      chk("halt_flag", 32'({halted, err}), 32'b10);
      drv(3'd0, 1'b1, 1'b1, 1'b0);
      repeat (3) adv();
      chk("halt_hold", 32'(state), 32'd5);
      chk("halt_strobes", 32'(strobes()), 32'd0);

      // counter wrap: preload 0xFFFF, retire one branch
      do_reset();
      drv(3'd4, 1'b1, 1'b0, 1'b0);
      adv();
      drv(3'd4, 1'b0, 1'b0, 1'b1);
      force dut.cnt_q = 16'hFFFF;
      adv();
      release dut.cnt_q;
      #1;
      chk("wrap_pre", 32'(instr_count), 32'hFFFF);
      adv();
      chk("wrap_state", 32'(state), 32'd0);
      chk("wrap_cnt", 32'(instr_count), 32'd0);

      // reset mid-MEM store drops dmem_req with no clock edge
      do_reset();
      drv(3'd3, 1'b1, 1'b0, 1'b0);
      adv();
      drv(3'd3, 1'b0, 1'b0, 1'b0);
      adv();
      adv();
      chk("mst_req", 32'({dmem_req, dmem_we}), 32'b11);
      rst_n = 1'b0;
      #1;
      chk("mst_drop", 32'({dmem_req, dmem_we}), 32'b00);
      chk("mst_state", 32'(state), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("mst_rel", 32'({imem_req, dmem_we}), 32'b10);
      adv();
      chk("mst_first", 32'({imem_req, dmem_we}), 32'b10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

endmodule
